// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and channel state encodings.
package axi_lite_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_slave_bram.sv
// Single-clock word RAM: byte-enable write port, read-first synchronous read port.
module axi_slave_bram #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic              S_AXI_ACLK,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [MEM_AW-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    // Byte-masked write; only enabled lanes are touched.
    always_ff @(posedge S_AXI_ACLK) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; a same-edge write is not visible (read-first).
    always_ff @(posedge S_AXI_ACLK) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4-Lite responder backed by a byte-enable word memory, with status counters.
module axi_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int unsigned                      C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                      C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                      MEM_AW             = 8,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]    BASE_ADDR          = '0
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [31:0]                         wr_count,
    output logic [31:0]                         rd_count,
    output logic                                err_sticky
);

    localparam int unsigned WIN_SHIFT = MEM_AW + ADDR_LSB;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                          awready, wready, bvalid, arready, rvalid;
    logic [1:0]                    bresp, rresp;
    logic                          aw_held, w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          aw_hs, w_hs, b_hs, wr_commit;
    logic                          ar_hs, r_hs, rd_sample;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_off, rd_off;
    logic                          wr_in_range, rd_in_range;
    logic [31:0]                   ram_q;
    logic                          unused_bits;

    assign wr_off      = awaddr_q - BASE_ADDR;
    assign rd_off      = araddr_q - BASE_ADDR;
    assign wr_in_range = (wr_off >> WIN_SHIFT) == '0;
    assign rd_in_range = (rd_off >> WIN_SHIFT) == '0;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_off[1:0], rd_off[1:0]};

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    // RAM output is not reset, so it is masked whenever no OKAY response is presented.
    assign S_AXI_RDATA   = (rvalid && rresp == RESP_OKAY) ? ram_q : '0;

    // Write channel state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) wr_state <= W_IDLE;
        else              wr_state <= wr_next;
    end

    // Write channel next-state and handshake decode.
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        aw_hs     = S_AXI_AWVALID && awready;
        w_hs      = S_AXI_WVALID && wready;
        b_hs      = bvalid && S_AXI_BREADY;
        case (wr_state)
            W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = W_COMMIT;
            W_COMMIT: begin
                wr_commit = 1'b1;
                wr_next   = W_RESP;
            end
            W_RESP:   if (b_hs) wr_next = W_IDLE;
            default:  wr_next = W_IDLE;
        endcase
    end

    // Write channel capture, response and completion count.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_count <= '0;
        end else begin
            awready <= (wr_next == W_IDLE) && !(aw_held || aw_hs);
            wready  <= (wr_next == W_IDLE) && !(w_held || w_hs);
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= S_AXI_AWADDR;
            end else if (wr_commit) begin
                aw_held  <= 1'b0;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end else if (wr_commit) begin
                w_held  <= 1'b0;
            end
            if (wr_commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid   <= 1'b0;
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    // Read channel state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) rd_state <= R_IDLE;
        else              rd_state <= rd_next;
    end

    // Read channel next-state and handshake decode.
    always_comb begin
        rd_next   = rd_state;
        ar_hs     = S_AXI_ARVALID && arready;
        r_hs      = rvalid && S_AXI_RREADY;
        rd_sample = 1'b0;
        case (rd_state)
            R_IDLE: if (ar_hs) rd_next = R_DATA;
            R_DATA: begin
                rd_sample = !rvalid;
                if (r_hs) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read channel capture, response and completion count.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rd_count <= '0;
        end else begin
            arready <= (rd_next == R_IDLE);
            if (ar_hs) araddr_q <= S_AXI_ARADDR;
            if (rd_sample) begin
                rvalid <= 1'b1;
                rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (r_hs) begin
                rvalid   <= 1'b0;
                rd_count <= rd_count + 32'd1;
            end
        end
    end

    // Sticky error flag, set on the edge an SLVERR response is launched.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) err_sticky <= 1'b0;
        else if ((wr_commit && !wr_in_range) || (rd_sample && !rd_in_range)) err_sticky <= 1'b1;
    end

    axi_slave_bram #(
        .MEM_AW (MEM_AW)
    ) u_bram (
        .S_AXI_ACLK (S_AXI_ACLK),
        .we         (wr_commit && wr_in_range),
        .be         (wstrb_q),
        .waddr      (wr_off[WIN_SHIFT-1:ADDR_LSB]),
        .wdata      (wdata_q),
        .re         (rd_sample),
        .raddr      (rd_off[WIN_SHIFT-1:ADDR_LSB]),
        .rdata      (ram_q)
    );

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
AXI4-Lite responder (slave) backed by a byte-enable word memory. It is the target-side counterpart to the scan IP's AXI4-Lite DMA master, and serves single-beat reads and writes from that master, or any AXI4-Lite initiator, in bench and on-chip loopback. Read and write channels are independent, each with one outstanding transaction. Out-of-range accesses get SLVERR. Status counters are exposed for the scan/debug logic.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI address width.
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
MEM_AW, 8, log2 of memory depth in words (default 256 words = 1 KiB).
BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^MEM_AW.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  32  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
wr_count  out  32  completed B handshakes, wraps at 2^32
rd_count  out  32  completed R handshakes, wraps at 2^32
err_sticky  out  1  set by any SLVERR response; cleared only by reset

Behaviour:
- Reset (S_AXI_ARESET=1 at edge): all READY and VALID outputs 0; BRESP, RRESP and RDATA 0; counters 0; err_sticky 0; internal latches empty. Memory contents are not reset.
- READYs are registered. At the first edge with reset low: AWREADY=WREADY=ARREADY=1.
- Address decode: off = addr - BASE_ADDR. In range iff off < 4*2^MEM_AW. Word index = off[MEM_AW+1:2]. Address bits [1:0] are ignored.
- Write path FSM, states W_IDLE, W_COMMIT, W_RESP:
  - AW and W are captured independently. AWREADY drops in the cycle after the AW handshake; WREADY drops in the cycle after the W handshake. Either may arrive first, or both in the same cycle.
  - When both are held, go to W_COMMIT. On that edge, write the memory bytes selected by WSTRB (WSTRB=0 writes nothing and still responds OKAY).
  - On the same edge: BVALID=1 and BRESP=OKAY (00), or SLVERR (10) if out of range. Out-of-range writes do not touch memory. Enter W_RESP.
  - Latency: AW+W in the same cycle at edge T gives memory updated and BVALID=1 at T+1.
  - BVALID holds, with BRESP stable, until BREADY. On the B handshake: BVALID=0, AWREADY=WREADY=1 next cycle, wr_count+1. Return to W_IDLE.
- Read path FSM, states R_IDLE, R_DATA:
  - AR handshake at edge T drops ARREADY. The synchronous RAM read gives RVALID=1 with RDATA at T+1.
  - RRESP=OKAY, or SLVERR with RDATA=0 if out of range.
  - RVALID, RDATA and RRESP hold until RREADY. On the R handshake: RVALID=0, ARREADY=1 next cycle, rd_count+1.
- Simultaneous events:
  - The read and write channels run fully concurrently.
  - If a write commits and a read samples the same word on the same edge, the read returns the pre-write data (read-first).
  - err_sticky sets on the edge that asserts an SLVERR response. Counter increments from both channels may occur in the same cycle.
- Reset mid-transaction: reset aborts any outstanding B or R response (VALID forced to 0). A write not yet committed is discarded. A committed write stays in memory.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ADDR_LSB=2, and the write/read state encodings.
- Sub-module axi_slave_bram: single-clock RAM with 2^MEM_AW x 32 bits, one write port with 4-bit byte enable, one read-first synchronous read port.

Test Plan:
1. Reset, then AW=0x10 and W=0xDEADBEEF with WSTRB=1111 in the same cycle -> BVALID at +1 cycle with BRESP=00. A following read of 0x10 returns RDATA=0xDEADBEEF, RRESP=00, RVALID at +1 after the AR handshake. wr_count=1, rd_count=1.
2. W=0x11223344 sent 3 cycles before AW=0x20 -> WREADY low until B completes, then BVALID 1 cycle after the AW handshake. Next, WSTRB=0010 with data 0xAABBCCDD to 0x20 -> reading 0x20 returns 0x1122CC44.
3. Write to 0x400, then read 0x7FC -> BRESP=10 and RRESP=10 with RDATA=0. Memory word 0 is unchanged. err_sticky=1.
4. Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID, RVALID, BRESP, RRESP and RDATA stay stable. AWREADY and ARREADY stay 0 until the respective handshake.
5. Word 0x30 holds 0x1 and has a read outstanding; issue a write of 0x2 committing on the same edge as the read sample -> RDATA=0x1, then a subsequent read returns 0x2.
6. Assert reset while BVALID=1 and RVALID=1 -> both outputs 0 at the next edge, counters 0, err_sticky 0, and READYs 1 one cycle after reset drops.
